// File: rtl/filter_stream_pkg.sv
// Shared types and constants for the filter output UART streamer.
// frame_byte() maps a frame index 0..8 to the byte sent on the line.
package filter_stream_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 9;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} frame_state_t;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  typedef struct packed {
    logic [31:0] lp;
    logic [31:0] hp;
  } sample_pair_t;

  function automatic logic [7:0] frame_byte(input sample_pair_t pair, input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = SYNC_BYTE;
      4'd1:    b = pair.lp[31:24];
      4'd2:    b = pair.lp[23:16];
      4'd3:    b = pair.lp[15:8];
      4'd4:    b = pair.lp[7:0];
      4'd5:    b = pair.hp[31:24];
      4'd6:    b = pair.hp[23:16];
      4'd7:    b = pair.hp[15:8];
      4'd8:    b = pair.hp[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/filter_output_streamer_uart_tx.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit.
// state    | meaning
// TX_IDLE  | line high, waiting for start
// TX_START | driving the start bit (0)
// TX_DATA  | shifting out data bits 0..7
// TX_STOP  | driving the stop bit (1); done on its last cycle
module uart_tx_byte
  import filter_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       ready
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tx_nxt;
  logic          bit_end;

  assign bit_end = (clk_cnt == LAST_CLK);
  assign ready   = (state == TX_IDLE);

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = bit_end ? '0 : clk_cnt + CW'(1);
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    tx_nxt      = tx;
    done        = 1'b0;
    case (state)
      TX_IDLE: begin
        clk_cnt_nxt = '0;
        if (start) begin
          shreg_nxt = data;
          tx_nxt    = 1'b0;
          state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          tx_nxt      = shreg[0];
          bit_cnt_nxt = 3'd0;
          state_nxt   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = TX_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shreg_nxt   = shreg >> 1;
            tx_nxt      = shreg[1];
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          done      = 1'b1;
          state_nxt = TX_IDLE;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      tx      <= tx_nxt;
    end
  end

endmodule

// File: rtl/filter_output_streamer.sv
// Buffers low_pass/high_pass pairs in a FIFO and sends each as a 9-byte UART frame.
// state | meaning
// IDLE  | waiting for a buffered pair; pops it into the holding register
// LOAD  | selects the byte for the current index and requests transmission
// WAIT  | waiting for the byte transmitter to finish
module filter_output_streamer
  import filter_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [31:0] low_pass,
  input  logic [31:0] high_pass,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  LAST_IDX = 4'(FRAME_BYTES - 1);

  sample_pair_t  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nxt;
  logic          wr_en, pop;

  frame_state_t  state, state_nxt;
  logic [3:0]    idx, idx_nxt;
  logic          load;
  sample_pair_t  hold;
  logic          byte_start;
  logic [7:0]    byte_data;
  logic          byte_done, byte_ready;

  // Acceptance looks only at occupancy before the edge, so a same-cycle pop never frees room.
  assign wr_en = sample_valid && (count < FULL_CNT);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pop       = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && byte_ready) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (byte_done) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = 4'd0;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + (PW+1)'(1);
      2'b01:   count_nxt = count - (PW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr] <= {low_pass, high_pass};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      idx        <= '0;
      hold       <= '0;
      byte_start <= 1'b0;
      byte_data  <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        hold   <= fifo_mem[rd_ptr];
      end
      count      <= count_nxt;
      state      <= state_nxt;
      idx        <= idx_nxt;
      byte_start <= load;
      if (load) byte_data <= frame_byte(hold, idx);
      busy       <= (count_nxt != '0) || (state_nxt != IDLE);
      if (sample_valid && !wr_en) overflow <= 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .rst  (rst),
    .start(byte_start),
    .data (byte_data),
    .tx   (tx),
    .done (byte_done),
    .ready(byte_ready)
  );

endmodule

// File: tb/tb_filter_output_streamer.sv
// Directed bench for filter_output_streamer: timing-level line model, UART decoder and scoreboard.
module tb_filter_output_streamer;

  localparam int C         = 4;
  localparam int D         = 4;
  localparam int STRIDE    = 10*C + 2;
  localparam int FRAME_LEN = 9*10*C + 8*2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] low_pass = '0;
  logic [31:0] high_pass = '0;
  logic        tx, busy, overflow;

  always #5 clk = ~clk;

  filter_output_streamer #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .low_pass    (low_pass),
    .high_pass   (high_pass),
    .tx          (tx),
    .busy        (busy),
    .overflow    (overflow)
  );

  typedef struct {
    int          w;
    logic [63:0] d;
  } ent_t;

  ent_t        pend[$];
  logic [7:0]  sb[$];
  logic [7:0]  dec_log[$];
  int          start_edges[$];

  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          m_ovf = 1'b0;
  bit          have_frame = 1'b0;
  int          cur_fall = 0, cur_end = 0, free_at = 0;
  logic [63:0] cur_pair = '0;
  int          last_rst_edge = -1;

  bit          dec_active = 1'b0;
  int          dn = 0;
  logic [7:0]  dec_byte = '0;

  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [7:0] byte_of(input logic [63:0] d, input int k);
    logic [63:0] s;
    if (k == 0) return 8'hA5;
    s = d >> (8*(8-k));
    return s[7:0];
  endfunction

  function automatic logic exp_tx_f();
    int o, k, r, b;
    logic [7:0] v;
    if (!have_frame || cyc < cur_fall) return 1'b1;
    o = cyc - cur_fall;
    k = o / STRIDE;
    r = o % STRIDE;
    if (k > 8) return 1'b1;
    if (r >= 10*C) return 1'b1;
    b = r / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    v = byte_of(cur_pair, k);
    return v[b-1];
  endfunction

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Frame k of the line starts 2 cycles after its pop; a pop needs the previous frame finished.
  task automatic model_update();
    int   occ;
    ent_t e;
    if (rst) begin
      pend.delete();
      sb.delete();
      m_ovf         = 1'b0;
      have_frame    = 1'b0;
      cur_end       = 0;
      free_at       = 0;
      last_rst_edge = cyc;
      chk_en        = 1'b1;
    end else begin
      occ = pend.size();
      if (pend.size() > 0 && cyc >= free_at && cyc >= pend[0].w + 1) begin
        e          = pend.pop_front();
        cur_pair   = e.d;
        cur_fall   = cyc + 2;
        cur_end    = cyc + 2 + FRAME_LEN;
        free_at    = cur_end + 1;
        have_frame = 1'b1;
        for (int k = 0; k < 9; k++) sb.push_back(byte_of(e.d, k));
      end
      if (sample_valid) begin
        if (occ < D) begin
          e.w = cyc;
          e.d = {low_pass, high_pass};
          pend.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic monitor();
    int j;
    if (!chk_en) return;
    check1("tx", tx, exp_tx_f());
    check1("busy", busy, (pend.size() > 0) || (have_frame && cyc < cur_end));
    check1("overflow", overflow, m_ovf);
    if (last_rst_edge == cyc) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (tx === 1'b0) begin
        dec_active = 1'b1;
        dn = 0;
        start_edges.push_back(cyc);
      end
    end else begin
      dn++;
      if (dn >= C + C/2 && dn < 9*C && ((dn - C - C/2) % C) == 0) begin
        j = (dn - C - C/2) / C;
        dec_byte[j] = tx;
      end else if (dn == 9*C + C/2) begin
        check1("stop_bit", tx, 1);
        dec_log.push_back(dec_byte);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL byte_sb: got %0h expected no byte at edge %0d", dec_byte, cyc);
        end else begin
          check1("byte_sb", dec_byte, sb.pop_front());
        end
        dec_active = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_update();
    @(negedge clk);
    monitor();
  endtask

  task automatic strobe(input logic [31:0] lp, input logic [31:0] hp);
    sample_valid = 1'b1;
    low_pass     = lp;
    high_pass    = hp;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int t = 0;
    while (dec_log.size() < n && t < budget) begin
      tick();
      t++;
    end
    check1("wait_bytes_timeout", dec_log.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      tick();
      t++;
    end
    check1("idle_timeout", busy, 0);
  endtask

  task automatic clear_logs();
    dec_log.delete();
    start_edges.delete();
  endtask

  initial begin
    int          n_edge;
    logic [7:0]  exp2 [9];
    logic [7:0]  exp5 [9];

    // 1: reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check1("rst_tx", tx, 1);
      check1("rst_busy", busy, 0);
      check1("rst_ovf", overflow, 0);
    end

    // 2: single frame
    clear_logs();
    exp2 = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
    strobe(32'h0001_0000, 32'hFFFF_0000);
    n_edge = cyc;
    check1("busy_rise", busy, 1);
    wait_bytes(9, 600);
    check1("first_fall_latency", start_edges[0] - n_edge, 3);
    check1("byte_stride", start_edges[1] - start_edges[0], STRIDE);
    for (int k = 0; k < 9; k++) check1("single_frame_byte", dec_log[k], exp2[k]);
    wait_idle(200);
    check1("busy_fall", cyc - start_edges[0], 376);

    // 3: back-to-back samples
    clear_logs();
    for (int k = 1; k <= 3; k++) begin
      sample_valid = 1'b1;
      low_pass     = 32'(k);
      high_pass    = ~32'(k);
      tick();
    end
    sample_valid = 1'b0;
    wait_bytes(27, 2000);
    check1("frame_spacing_1", start_edges[9] - start_edges[0], 379);
    check1("frame_spacing_2", start_edges[18] - start_edges[9], 379);
    check1("inter_frame_gap", start_edges[9] - (start_edges[8] + 10*C), 3);
    check1("b2b_lp1", dec_log[4], 8'h01);
    check1("b2b_lp2", dec_log[13], 8'h02);
    check1("b2b_lp3", dec_log[22], 8'h03);
    check1("b2b_hp1_msb", dec_log[5], 8'hFF);
    check1("b2b_hp1_lsb", dec_log[8], 8'hFE);
    check1("b2b_ovf", overflow, 0);
    wait_idle(500);

    // 4: overflow
    clear_logs();
    for (int k = 1; k <= 6; k++) begin
      sample_valid = 1'b1;
      low_pass     = 32'(k);
      high_pass    = 32'hABCD_0000 | 32'(k);
      tick();
    end
    sample_valid = 1'b0;
    check1("ovf_set", overflow, 1);
    wait_bytes(45, 3000);
    wait_idle(500);
    check1("ovf_frame_count", dec_log.size(), 45);
    for (int f = 0; f < 5; f++) check1("ovf_frame_lp", dec_log[9*f+4], 8'(f+1));
    check1("ovf_sticky", overflow, 1);

    // 5: reset mid-frame
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
    strobe(32'h1234_5678, 32'h9ABC_DEF0);
    begin
      int t = 0;
      while (start_edges.size() < 5 && t < 400) begin
        tick();
        t++;
      end
      check1("byte4_timeout", start_edges.size() >= 5, 1);
    end
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("midrst_tx", tx, 1);
    check1("midrst_busy", busy, 0);
    check1("midrst_ovf", overflow, 0);
    repeat (10) tick();
    check1("midrst_bytes", dec_log.size(), 4);
    check1("midrst_idle_tx", tx, 1);
    clear_logs();
    exp5 = '{8'hA5, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0B, 8'hAD, 8'hBE, 8'hEF};
    strobe(32'hCAFE_F00D, 32'h0BAD_BEEF);
    wait_bytes(9, 600);
    for (int k = 0; k < 9; k++) check1("post_rst_byte", dec_log[k], exp5[k]);
    wait_idle(200);

    // 6: random pairs one frame apart
    clear_logs();
    for (int i = 0; i < 50; i++) begin
      strobe($urandom, $urandom);
      repeat (379) tick();
    end
    wait_idle(500);
    check1("rand_bytes", dec_log.size(), 450);
    check1("rand_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
